// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a valid/ready input, a registered output stage and one skid
// entry so the block sustains one instruction per cycle under back-pressure.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam bit Rv64 = (XLEN == 64);

   localparam logic [6:0] OpLoad    = 7'b0000011;
   localparam logic [6:0] OpMiscMem = 7'b0001111;
   localparam logic [6:0] OpOpImm   = 7'b0010011;
   localparam logic [6:0] OpOpImm32 = 7'b0011011;
   localparam logic [6:0] OpJalr    = 7'b1100111;
   localparam logic [6:0] OpSystem  = 7'b1110011;
   localparam logic [6:0] OpStore   = 7'b0100011;
   localparam logic [6:0] OpBranch  = 7'b1100011;
   localparam logic [6:0] OpLui     = 7'b0110111;
   localparam logic [6:0] OpAuipc   = 7'b0010111;
   localparam logic [6:0] OpJal     = 7'b1101111;
   localparam logic [6:0] OpOp      = 7'b0110011;
   localparam logic [6:0] OpOp32    = 7'b0111011;
   localparam logic [6:0] OpAmo     = 7'b0101111;

   localparam logic [2:0] FmtNone = 3'd0;
   localparam logic [2:0] FmtI    = 3'd1;
   localparam logic [2:0] FmtS    = 3'd2;
   localparam logic [2:0] FmtB    = 3'd3;
   localparam logic [2:0] FmtU    = 3'd4;
   localparam logic [2:0] FmtJ    = 3'd5;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             ill;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e     state_q, state_d;
   logic       in_ready_q;
   entry_t     main_q, skid_q, dec;
   logic [6:0] opcode;
   logic [2:0] dec_fmt;
   logic       dec_ill;
   logic [31:0] dec_imm32;
   logic       accept, fire;
   logic       load_main, load_skid, skid_to_main;

   assign opcode = in_instr[6:0];

   always_comb begin
      dec_fmt = FmtNone;
      dec_ill = 1'b0;
      case (opcode)
         OpLoad, OpMiscMem, OpOpImm, OpJalr, OpSystem: dec_fmt = FmtI;
         OpOpImm32: begin
            dec_fmt = Rv64 ? FmtI : FmtNone;
            dec_ill = !Rv64;
         end
         OpStore:        dec_fmt = FmtS;
         OpBranch:       dec_fmt = FmtB;
         OpLui, OpAuipc: dec_fmt = FmtU;
         OpJal:          dec_fmt = FmtJ;
         OpOp, OpAmo:    dec_fmt = FmtNone;
         OpOp32:         dec_ill = !Rv64;
         default:        dec_ill = 1'b1;
      endcase
   end

   // Build a 32-bit immediate first; every format sign-extends from instr[31].
   always_comb begin
      dec_imm32 = '0;
      case (dec_fmt)
         FmtI: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FmtS: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FmtB: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
         FmtU: dec_imm32 = {in_instr[31:12], 12'b0};
         FmtJ: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
         default: dec_imm32 = '0;
      endcase
   end

   always_comb begin
      dec.imm = XLEN'($signed(dec_imm32));
      dec.fmt = dec_fmt;
      dec.ill = dec_ill;
      dec.tag = in_tag;
   end

   assign accept = in_valid & in_ready_q;
   assign fire   = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d   = StOne;
               load_main = 1'b1;
            end
         end
         StOne: begin
            if (accept && fire) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = StFull;
               load_skid = 1'b1;
            end else if (fire) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (fire) begin
               state_d      = StOne;
               skid_to_main = 1'b1;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Flush drops everything, including an instruction offered on the same cycle.
      if (flush) begin
         state_d      = StEmpty;
         load_main    = 1'b0;
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != StFull);
         if (load_main) begin
            main_q <= dec;
         end else if (skid_to_main) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= dec;
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != StEmpty);
   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.ill;
   assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 and an RV64 instance share one input stream and are checked
// against directed constants and a queue-based reference model.
module tb_imm_gen_pipe;

   localparam int TW = 32;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, out_ready;
   logic [31:0]   in_instr;
   logic [TW-1:0] in_tag;

   logic          in_ready32, out_valid32, out_ill32;
   logic [31:0]   out_imm32;
   logic [2:0]    out_fmt32;
   logic [TW-1:0] out_tag32;
   logic          in_ready64, out_valid64, out_ill64;
   logic [63:0]   out_imm64;
   logic [2:0]    out_fmt64;
   logic [TW-1:0] out_tag64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]   w;
      logic [TW-1:0] tag;
   } ent_t;
   ent_t q[$];

   logic [31:0] tw  [10] = '{32'h06432283, 32'h0653A223, 32'hFFF00093, 32'hFE000EE3,
                             32'h0080006F, 32'h123450B7, 32'h0010009B, 32'h0000003B,
                             32'h00000033, 32'h0000007F};
   logic [31:0] e32 [10] = '{32'h64, 32'h64, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8, 32'h12345000,
                             32'h0, 32'h0, 32'h0, 32'h0};
   logic [2:0]  f32 [10] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd5, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
   logic        i32 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [63:0] e64 [10] = '{64'h64, 64'h64, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                             64'h12345000, 64'h1, 64'h0, 64'h0, 64'h0};
   logic [2:0]  f64 [10] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd5, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0};
   logic        i64 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   logic [6:0]  ops [14] = '{7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h33, 7'h3B, 7'h2F};

   imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_ill32), .out_tag(out_tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_ill64), .out_tag(out_tag64)
   );

   always #5 clk = ~clk;

   // Reference decode straight from the opcode table and bit-field rules.
   function automatic logic [2:0] m_fmt(input logic [31:0] w, input bit rv64);
      case (w[6:0])
         7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: return 3'd1;
         7'h1B:        return rv64 ? 3'd1 : 3'd0;
         7'h23:        return 3'd2;
         7'h63:        return 3'd3;
         7'h37, 7'h17: return 3'd4;
         7'h6F:        return 3'd5;
         default:      return 3'd0;
      endcase
   endfunction

   function automatic logic m_ill(input logic [31:0] w, input bit rv64);
      if (m_fmt(w, rv64) != 3'd0) return 1'b0;
      if (w[6:0] == 7'h33 || w[6:0] == 7'h2F) return 1'b0;
      if (w[6:0] == 7'h3B) return !rv64;
      return 1'b1;
   endfunction

   function automatic logic [63:0] m_imm(input logic [31:0] w, input bit rv64);
      longint v;
      case (m_fmt(w, rv64))
         3'd1: v = longint'($signed(w[31:20]));
         3'd2: v = longint'($signed({w[31:25], w[11:7]}));
         3'd3: v = longint'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
         3'd4: v = longint'($signed(w[31:12])) * 4096;
         3'd5: v = longint'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
         default: v = 0;
      endcase
      return 64'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_tag = '0;
      tick(); tick();
      checks++;
      if ({out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32, in_ready32} !==
          {1'b0, 32'h0, 3'h0, 1'b0, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL reset32 got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b exp 0/0/0/0/0/1",
                  out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32, in_ready32);
      end
      checks++;
      if ({out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64, in_ready64} !==
          {1'b0, 64'h0, 3'h0, 1'b0, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL reset64 got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b exp 0/0/0/0/0/1",
                  out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64, in_ready64);
      end
      rst_n = 1'b1;
   endtask

   // Back-to-back stream with out_ready=1: each result appears one edge after its accept.
   task automatic test_formats();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_instr = tw[i]; in_tag = TW'(100 + i);
         tick();
         checks++;
         if ({out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32, in_ready32} !==
             {1'b1, e32[i], f32[i], i32[i], TW'(100 + i), 1'b1}) begin
            errors++;
            $display("FAIL fmt32[%0d] got v=%b imm=%h fmt=%0d ill=%b tag=%0d exp imm=%h fmt=%0d ill=%b",
                     i, out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32,
                     e32[i], f32[i], i32[i]);
         end
         checks++;
         if ({out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64, in_ready64} !==
             {1'b1, e64[i], f64[i], i64[i], TW'(100 + i), 1'b1}) begin
            errors++;
            $display("FAIL fmt64[%0d] got v=%b imm=%h fmt=%0d ill=%b tag=%0d exp imm=%h fmt=%0d ill=%b",
                     i, out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64,
                     e64[i], f64[i], i64[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
         errors++;
         $display("FAIL drain got v32=%b v64=%b exp 0", out_valid32, out_valid64);
      end
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] exp_tag [3] = '{TW'('hA), TW'('hB), TW'('hC)};
      logic [31:0]   exp_imm [3] = '{32'h64, 32'hFFFFFFFC, 32'h12345000};
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = tw[0]; in_tag = exp_tag[0];
      tick();
      checks++;
      if ({out_valid32, out_tag32, in_ready32} !== {1'b1, exp_tag[0], 1'b1}) begin
         errors++;
         $display("FAIL bp_first got v=%b tag=%h rdy=%b exp 1/a/1", out_valid32, out_tag32,
                  in_ready32);
      end
      in_instr = tw[3]; in_tag = exp_tag[1];
      tick();
      checks++;
      if ({in_ready32, in_ready64} !== 2'b00) begin
         errors++;
         $display("FAIL bp_full got rdy32=%b rdy64=%b exp 0", in_ready32, in_ready64);
      end
      in_instr = tw[5]; in_tag = exp_tag[2];
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({out_valid32, out_imm32, out_tag32, in_ready32} !==
             {1'b1, exp_imm[0], exp_tag[0], 1'b0}) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%b imm=%h tag=%h rdy=%b exp 1/%h/%h/0", k,
                     out_valid32, out_imm32, out_tag32, in_ready32, exp_imm[0], exp_tag[0]);
         end
      end
      out_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         tick();
         checks++;
         if ({out_valid32, out_imm32, out_tag32, out_tag64} !==
             {1'b1, exp_imm[k], exp_tag[k], exp_tag[k]}) begin
            errors++;
            $display("FAIL bp_out[%0d] got v=%b imm=%h tag=%h exp 1/%h/%h", k, out_valid32,
                     out_imm32, out_tag32, exp_imm[k], exp_tag[k]);
         end
         if (k == 1) begin
            checks++;
            if (in_ready32 !== 1'b1) begin
               errors++;
               $display("FAIL bp_rdy got %b exp 1", in_ready32);
            end
         end
         in_valid = (k == 1);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
         errors++;
         $display("FAIL bp_end got v32=%b v64=%b exp 0", out_valid32, out_valid64);
      end
   endtask

   task automatic fill_full();
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = tw[2]; in_tag = 'h1; tick();
      in_instr = tw[4]; in_tag = 'h2; tick();
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      fill_full();
      checks++;
      if (in_ready32 !== 1'b0) begin
         errors++;
         $display("FAIL flush_pre got rdy=%b exp 0", in_ready32);
      end
      flush = 1'b1; in_valid = 1'b1; in_instr = tw[5]; in_tag = 'hD;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if ({out_valid32, in_ready32, out_valid64, in_ready64} !== 4'b0101) begin
         errors++;
         $display("FAIL flush got v32=%b rdy32=%b v64=%b rdy64=%b exp 0/1/0/1", out_valid32,
                  in_ready32, out_valid64, in_ready64);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL flush_after[%0d] got v32=%b v64=%b exp 0", k, out_valid32,
                     out_valid64);
         end
      end
   endtask

   task automatic test_reset_full();
      fill_full();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32, in_ready32} !==
          {1'b0, 32'h0, 3'h0, 1'b0, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL rst_full32 got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b exp 0/0/0/0/0/1",
                  out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32, in_ready32);
      end
      checks++;
      if ({out_valid64, out_imm64, out_tag64, in_ready64} !== {1'b0, 64'h0, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL rst_full64 got v=%b imm=%h tag=%h rdy=%b exp 0/0/0/1", out_valid64,
                  out_imm64, out_tag64, in_ready64);
      end
      rst_n = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL rst_after[%0d] got v32=%b v64=%b exp 0", k, out_valid32, out_valid64);
         end
      end
   endtask

   task automatic test_random();
      ent_t        e;
      logic [63:0] x32, x64;
      logic [31:0] w;
      bit          rdy, fire;
      flush = 1'b1; in_valid = 1'b0; tick(); flush = 1'b0;
      q.delete();
      for (int c = 0; c < 800; c++) begin
         if (q.size() > 0) begin
            e = q[0];
            x32 = m_imm(e.w, 1'b0);
            x64 = m_imm(e.w, 1'b1);
            checks++;
            if ({out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32} !==
                {1'b1, x32[31:0], m_fmt(e.w, 1'b0), m_ill(e.w, 1'b0), e.tag}) begin
               errors++;
               $display("FAIL rand32 c=%0d w=%h got v=%b imm=%h fmt=%0d ill=%b tag=%h exp imm=%h tag=%h",
                        c, e.w, out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32,
                        x32[31:0], e.tag);
            end
            checks++;
            if ({out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64} !==
                {1'b1, x64, m_fmt(e.w, 1'b1), m_ill(e.w, 1'b1), e.tag}) begin
               errors++;
               $display("FAIL rand64 c=%0d w=%h got v=%b imm=%h fmt=%0d ill=%b tag=%h exp imm=%h tag=%h",
                        c, e.w, out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64, x64,
                        e.tag);
            end
         end else begin
            checks++;
            if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
               errors++;
               $display("FAIL rand_empty c=%0d got v32=%b v64=%b exp 0", c, out_valid32,
                        out_valid64);
            end
         end
         rdy = (q.size() < 2);
         checks++;
         if (in_ready32 !== rdy || in_ready64 !== rdy) begin
            errors++;
            $display("FAIL rand_rdy c=%0d got rdy32=%b rdy64=%b exp %b", c, in_ready32,
                     in_ready64, rdy);
         end
         w = $urandom;
         if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(13)];
         in_instr  = w;
         in_tag    = $urandom;
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(31) == 0);
         if (flush) begin
            q.delete();
         end else begin
            fire = (q.size() > 0) && out_ready;
            if (fire) void'(q.pop_front());
            if (in_valid && rdy) q.push_back('{w: w, tag: in_tag});
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_formats();
      test_back_to_back();
      test_flush();
      test_reset_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator for the decode stage. Accepts one instruction word per cycle over a valid/ready handshake, classifies its immediate format, and produces the sign-extended XLEN-bit immediate plus a format code and an illegal-opcode flag. A one-cycle registered output stage with a skid entry allows full throughput under back-pressure. Supports RV32 and RV64 and carries a sideband tag (typically the PC) alongside each result.

## Interface

- XLEN, 32, immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  instruction presented.
- in_ready  output  1  block can accept; registered.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_illegal  output  1  opcode has no defined immediate format.
- out_tag  output  TAG_W  tag of the result.

## Operation

- Decode on in_instr[6:0]:
  - I: 0000011, 0001111, 0010011, 1100111, 1110011, plus 0011011 only when XLEN=64; imm = sext(instr[31:20]).
  - S: 0100011; imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: 0110111, 0010111; imm = sext({instr[31:12], 12'b0}).
  - J: 1101111; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type (0110011, 0111011 when XLEN=64, 0101111): fmt 0, imm 0, illegal 0.
  - Any other opcode: fmt 0, imm 0, illegal 1.
- Sign extension is always from instr[31] to XLEN bits.
- Storage: output register (main) plus one skid entry. States: EMPTY (no valid entry), ONE (main valid), FULL (main and skid valid).
  - EMPTY: in accept -> ONE.
  - ONE: accept without out fire -> FULL; out fire without accept -> EMPTY; both -> ONE, main reloaded.
  - FULL: out fire -> ONE, skid moves to main; in_ready is 0, so no accept.
- Accept = in_valid & in_ready. Out fire = out_valid & out_ready.
- Result ordering is strictly FIFO.
- flush: next state EMPTY, out_valid 0; in_valid on a flush cycle is ignored. rst_n has priority over flush.
- Reset mid-operation: all held entries are dropped with no output fire.

## Timing

- Latency: in accepted at edge N -> out_valid high after edge N, visible in cycle N+1.
- Throughput: one result per cycle while out_ready=1.
- in_ready = (state != FULL), registered; it does not combinationally depend on out_ready.
- When out_valid=1 and out_ready=0, out_* hold stable until the fire.
- Reset values after the reset edge: out_valid 0, out_imm 0, out_fmt 0, out_illegal 0, out_tag 0, in_ready 1, state EMPTY.
- After flush: in_ready 1 in the following cycle.

## Test plan

- XLEN=32, stream 0x06432283 then 0x0653A223 with out_ready=1 -> results on consecutive cycles: imm 0x00000064, fmt 1; then imm 0x00000064, fmt 2; latency 1.
- Sign and format coverage: 0xFFF00093 -> 0xFFFFFFFF, fmt 1. 0xFE000EE3 -> 0xFFFFFFFC, fmt 3. 0x0080006F -> 0x00000008, fmt 5. 0x123450B7 -> 0x12345000, fmt 4.
- XLEN=64:
  - 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
  - 0x0010009B (addiw) -> imm 1, fmt 1, illegal 0.
  - With XLEN=32, the same word -> illegal 1, fmt 0, imm 0.
- Back-pressure: hold out_ready=0 and drive 3 back-to-back words. Expected: in_ready drops after the 2nd accept; the 3rd is held at input; outputs stay stable. Then release out_ready -> all 3 emerge in order with tags intact, one per cycle.
- Flush in FULL, with in_valid=1 on the same cycle -> next cycle out_valid 0 and in_ready 1; the flushed and offered words never appear.
- rst_n low for one edge while FULL -> all outputs at reset values, with no spurious out_valid afterwards.
